updown_tick_ctrl: RTL

Run controller for the up/down counter datapath. It owns the clock-enable prescaler and sequences a bounded up/down count through a small state machine. The counter advances on a one-cycle tick enable in the `clock_in` domain; the block does not generate a derived clock. It sits between the board's push-button/switch conditioning and the display decoder, and drives `count` and status directly.

---
 rtl/updown_tick_ctrl_if.sv | 26 ++
 rtl/updown_tick_ctrl.sv | 127 ++++++++++++
 2 files changed

// File: rtl/updown_tick_ctrl_if.sv
// Command and status bundle between the front-panel conditioning logic
// and the up/down tick controller.
interface updown_tick_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             dir_up;
    logic             wrap_en;
    logic [WIDTH-1:0] count;
    logic             tick;
    logic             tc;
    logic             running;

    modport master (
        output start, stop, load, load_val, dir_up, wrap_en,
        input  count, tick, tc, running
    );

    modport slave (
        input  start, stop, load, load_val, dir_up, wrap_en,
        output count, tick, tc, running
    );
endinterface

// File: rtl/updown_tick_ctrl.sv
// Run controller for the bounded up/down counter: owns the clock-enable
// prescaler and sequences IDLE/RUN/DONE; all outputs are registered.
module updown_tick_ctrl #(
    parameter int DIVISOR = 50000000,
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = 9
) (
    input  logic                clock_in,
    input  logic                reset_n,
    updown_tick_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [27:0]      PRESC_LAST = 28'(DIVISOR - 1);
    localparam logic [WIDTH-1:0] MAX_C      = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ZERO_C     = {WIDTH{1'b0}};

    state_t           state_r, state_nxt_s;
    logic [27:0]      presc_r, presc_nxt_s;
    logic [WIDTH-1:0] count_r, count_nxt_s;
    logic             tick_r, tick_nxt_s;
    logic             tc_r, tc_nxt_s;
    logic             running_r;

    // Keeps a preset inside the legal count range.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        clamp_load = (v > MAX_C) ? MAX_C : v;
    endfunction

    // Next-state, next-count and prescaler logic; load overrides everything.
    always_comb begin
        state_nxt_s = state_r;
        presc_nxt_s = presc_r;
        count_nxt_s = count_r;
        tick_nxt_s  = 1'b0;
        tc_nxt_s    = 1'b0;
        if (bus.load) begin
            count_nxt_s = clamp_load(bus.load_val);
            presc_nxt_s = 28'd0;
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    presc_nxt_s = 28'd0;
                    if (bus.start) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (bus.stop) begin
                        state_nxt_s = ST_IDLE;
                        presc_nxt_s = 28'd0;
                    end else if (presc_r == PRESC_LAST) begin
                        presc_nxt_s = 28'd0;
                        tick_nxt_s  = 1'b1;
                        // A step at a limit either wraps or parks in DONE; both flag tc.
                        if (bus.dir_up) begin
                            if (count_r < MAX_C) begin
                                count_nxt_s = count_r + WIDTH'(1);
                            end else if (bus.wrap_en) begin
                                count_nxt_s = ZERO_C;
                                tc_nxt_s    = 1'b1;
                            end else begin
                                tc_nxt_s    = 1'b1;
                                state_nxt_s = ST_DONE;
                            end
                        end else begin
                            if (count_r != ZERO_C) begin
                                count_nxt_s = count_r - WIDTH'(1);
                            end else if (bus.wrap_en) begin
                                count_nxt_s = MAX_C;
                                tc_nxt_s    = 1'b1;
                            end else begin
                                tc_nxt_s    = 1'b1;
                                state_nxt_s = ST_DONE;
                            end
                        end
                    end else begin
                        presc_nxt_s = presc_r + 28'd1;
                    end
                end
                ST_DONE: begin
                    presc_nxt_s = 28'd0;
                    if (bus.start) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    presc_nxt_s = 28'd0;
                end
            endcase
        end
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            presc_r   <= 28'd0;
            count_r   <= ZERO_C;
            tick_r    <= 1'b0;
            tc_r      <= 1'b0;
            running_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            presc_r   <= presc_nxt_s;
            count_r   <= count_nxt_s;
            tick_r    <= tick_nxt_s;
            tc_r      <= tc_nxt_s;
            running_r <= (state_nxt_s == ST_RUN);
        end
    end

    assign bus.count   = count_r;
    assign bus.tick    = tick_r;
    assign bus.tc      = tc_r;
    assign bus.running = running_r;
endmodule
